// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO: owns the read pointer, empty flag and
// occupancy level, and hides the memory read latency behind a 2-entry output buffer.
module fifo_read_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic [ADDR_SIZE:0]   rd_wptr_sync,
  input  logic [DATA_SIZE-1:0] rd_data,
  output logic [ADDR_SIZE:0]   rd_ptr,
  output logic [ADDR_SIZE-1:0] rd_addr,
  output logic                 rd_inc,
  output logic                 rd_empty,
  output logic [ADDR_SIZE:0]   rd_level,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  function automatic logic [ADDR_SIZE:0] bin2gray(input logic [ADDR_SIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b = {(ADDR_SIZE+1){1'b0}};
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_SIZE:0]   rd_bin_r;
  logic [ADDR_SIZE:0]   rd_ptr_r;
  logic [ADDR_SIZE:0]   rd_level_r;
  logic                 rd_empty_r;
  logic [ADDR_SIZE:0]   rd_bin_next_s;
  logic [ADDR_SIZE:0]   rd_gray_next_s;
  logic [ADDR_SIZE:0]   wbin_s;
  logic [DATA_SIZE-1:0] buf0_r;
  logic [DATA_SIZE-1:0] buf1_r;
  logic [DATA_SIZE-1:0] buf0_next_s;
  logic [DATA_SIZE-1:0] buf1_next_s;
  logic [1:0]           occ_r;
  logic [1:0]           occ_next_s;
  logic [2:0]           occ_eff_s;
  logic                 inflight_r;
  logic                 out_valid_r;
  logic                 pop_s;
  logic                 rd_inc_s;

  // Issue decision and pointer look-ahead; occ_eff counts the slot an in-flight word will take
  always_comb begin
    pop_s     = out_valid_r & out_ready;
    occ_eff_s = {1'b0, occ_r} - {2'b00, pop_s} + {2'b00, inflight_r};
    if (rd_rst) begin
      rd_inc_s = 1'b0;
    end else begin
      rd_inc_s = !rd_empty_r && (occ_eff_s < 3'd2);
    end
    rd_bin_next_s  = rd_bin_r + {{ADDR_SIZE{1'b0}}, rd_inc_s};
    rd_gray_next_s = bin2gray(rd_bin_next_s);
    wbin_s         = gray2bin(rd_wptr_sync);
  end

  // Output buffer next state: buf0 is always the head, pops shift buf1 forward
  always_comb begin
    buf0_next_s = buf0_r;
    buf1_next_s = buf1_r;
    occ_next_s  = occ_r;
    case ({pop_s, inflight_r})
      2'b10: begin
        buf0_next_s = buf1_r;
        occ_next_s  = occ_r - 2'd1;
      end
      2'b01: begin
        if (occ_r == 2'd0) begin
          buf0_next_s = rd_data;
        end else begin
          buf1_next_s = rd_data;
        end
        occ_next_s = occ_r + 2'd1;
      end
      2'b11: begin
        if (occ_r == 2'd2) begin
          buf0_next_s = buf1_r;
          buf1_next_s = rd_data;
        end else begin
          buf0_next_s = rd_data;
        end
      end
      default: begin
        occ_next_s = occ_r;
      end
    endcase
  end

  // State registers; reset also drops any word still returning from memory
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_bin_r    <= {(ADDR_SIZE+1){1'b0}};
      rd_ptr_r    <= {(ADDR_SIZE+1){1'b0}};
      rd_empty_r  <= 1'b1;
      rd_level_r  <= {(ADDR_SIZE+1){1'b0}};
      buf0_r      <= {DATA_SIZE{1'b0}};
      buf1_r      <= {DATA_SIZE{1'b0}};
      occ_r       <= 2'd0;
      out_valid_r <= 1'b0;
      inflight_r  <= 1'b0;
    end else begin
      rd_bin_r    <= rd_bin_next_s;
      rd_ptr_r    <= rd_gray_next_s;
      rd_empty_r  <= (rd_gray_next_s == rd_wptr_sync);
      rd_level_r  <= wbin_s - rd_bin_next_s;
      buf0_r      <= buf0_next_s;
      buf1_r      <= buf1_next_s;
      occ_r       <= occ_next_s;
      out_valid_r <= (occ_next_s != 2'd0);
      inflight_r  <= rd_inc_s;
    end
  end

  assign rd_ptr    = rd_ptr_r;
  assign rd_addr   = rd_bin_r[ADDR_SIZE-1:0];
  assign rd_inc    = rd_inc_s;
  assign rd_empty  = rd_empty_r;
  assign rd_level  = rd_level_r;
  assign out_data  = buf0_r;
  assign out_valid = out_valid_r;

endmodule
